// File: rtl/hs_cdc_sync_array_pkg.sv
// Shared limits and helpers for the hs_cdc synchroniser array.
package hs_cdc_pkg;

    localparam int unsigned HS_CDC_SYNC_STAGE_MIN = 2;
    localparam int unsigned HS_CDC_SYNC_STAGE_MAX = 32;
    localparam int unsigned HS_CDC_FILTER_LEN_MAX = 256;
    localparam int unsigned HS_CDC_CH_NUM_MAX     = 64;

    // Filter counter width; a length of 1 still needs a 1-bit counter.
    function automatic int unsigned hs_cdc_cnt_w(input int unsigned len);
        int unsigned w;
        w = 32'($clog2(len));
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/hs_cdc_sync_array_glitch_filter.sv
// Per-channel stability filter: accepts a new level after FILTER_LEN agreeing samples.
// Edge pulse registers are built only when HS_CDC_SYNC_EDGE_EN is defined.
module hs_cdc_glitch_filter
    import hs_cdc_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4,
    parameter logic        RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic aresetn,
    input  logic sy_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned      CNT_W   = hs_cdc_cnt_w(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;

    // Any agreement cycle throws away the partial run.
    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        if (sy_i != dout_q) begin
            if (cnt_q == CNT_MAX) begin
                dout_d = sy_i;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q  <= '0;
            dout_q <= RESET_VAL;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

`ifdef HS_CDC_SYNC_EDGE_EN
    logic rise_q, fall_q;

    // Pulses land in the first cycle of the new dout level.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= dout_d & ~dout_q;
            fall_q <= ~dout_d & dout_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/hs_cdc_sync_array.sv
// CH_NUM-wide async input synchroniser with per-channel glitch filter.
// Define HS_CDC_SYNC_EDGE_EN to build the rise/fall/chg edge outputs.
module hs_cdc_sync_array
    import hs_cdc_pkg::*;
#(
    parameter int unsigned       CH_NUM     = 8,
    parameter int unsigned       SYNC_STAGE = 2,
    parameter int unsigned       FILTER_LEN = 4,
    parameter logic [CH_NUM-1:0] RESET_VAL  = '0
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [CH_NUM-1:0] din,
    output logic [CH_NUM-1:0] dout,
    output logic [CH_NUM-1:0] rise,
    output logic [CH_NUM-1:0] fall,
    output logic              chg
);

    if ((CH_NUM < 1) || (CH_NUM > HS_CDC_CH_NUM_MAX)) begin : g_bad_ch_num
        $error("hs_cdc_sync_array: CH_NUM out of range 1..64");
    end
    if ((SYNC_STAGE < HS_CDC_SYNC_STAGE_MIN) || (SYNC_STAGE > HS_CDC_SYNC_STAGE_MAX)) begin : g_bad_sync
        $error("hs_cdc_sync_array: SYNC_STAGE out of range 2..32");
    end
    if ((FILTER_LEN < 1) || (FILTER_LEN > HS_CDC_FILTER_LEN_MAX)) begin : g_bad_filt
        $error("hs_cdc_sync_array: FILTER_LEN out of range 1..256");
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        (* async_reg = "true" *) logic [SYNC_STAGE-1:0] s_q;
        logic [SYNC_STAGE-1:0] s_d;

        // s_q[0] is the metastability-catching stage, MSB feeds the filter.
        always_comb begin
            s_d = {s_q[SYNC_STAGE-2:0], din[i]};
        end

        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                s_q <= {SYNC_STAGE{RESET_VAL[i]}};
            end else begin
                s_q <= s_d;
            end
        end

        hs_cdc_glitch_filter #(
            .FILTER_LEN (FILTER_LEN),
            .RESET_VAL  (RESET_VAL[i])
        ) u_filt (
            .clk     (clk),
            .aresetn (aresetn),
            .sy_i    (s_q[SYNC_STAGE-1]),
            .dout_o  (dout[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

`ifdef HS_CDC_SYNC_EDGE_EN
    assign chg = |(rise | fall);
`else
    assign chg = 1'b0;
`endif

endmodule

// File: tb/tb_hs_cdc_sync_array.sv
// Directed bench for hs_cdc_sync_array (SYNC_STAGE=2, FILTER_LEN=4, RESET_VAL=8'hA5).
module tb_hs_cdc_sync_array;

    localparam logic [7:0] RV = 8'hA5;
`ifdef HS_CDC_SYNC_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       aresetn;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] acc_dout;
    logic [7:0] acc_rise;

    hs_cdc_sync_array #(
        .CH_NUM     (8),
        .SYNC_STAGE (2),
        .FILTER_LEN (4),
        .RESET_VAL  (RV)
    ) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .din     (din),
        .dout    (dout),
        .rise    (rise),
        .fall    (fall),
        .chg     (chg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, act, exp);
        end
    endtask

    // Edge outputs read as zero when the edge logic is not built.
    function automatic logic [7:0] ed(input logic [7:0] v);
        return EDGE_EN ? v : 8'h00;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_acc(input int n);
        repeat (n) begin
            step(1);
            acc_dout = acc_dout | dout;
            acc_rise = acc_rise | rise;
        end
    endtask

    initial begin
        aresetn  = 1'b0;
        din      = 8'hFF;
        acc_dout = '0;
        acc_rise = '0;

        // Reset state
        step(3);
        check_eq("rst_dout", dout, RV);
        check_eq("rst_rise", rise, 8'h00);
        check_eq("rst_fall", fall, 8'h00);
        check_eq("rst_chg", {7'd0, chg}, 8'h00);

        // Release with inputs matching reset level: no pulses
        din = RV;
        step(1);
        aresetn = 1'b1;
        step(1);
        check_eq("rel_dout", dout, RV);
        check_eq("rel_rise", rise, 8'h00);
        check_eq("rel_fall", fall, 8'h00);
        check_eq("rel_chg", {7'd0, chg}, 8'h00);
        step(3);
        check_eq("idle_dout", dout, RV);

        // All channels drop together
        din = 8'h00;
        step(5);
        check_eq("drop_pre_dout", dout, RV);
        step(1);
        check_eq("drop_dout", dout, 8'h00);
        check_eq("drop_fall", fall, ed(8'hA5));
        check_eq("drop_rise", rise, 8'h00);
        check_eq("drop_chg", {7'd0, chg}, ed(8'h01));
        step(1);
        check_eq("drop_fall_clr", fall, 8'h00);
        check_eq("drop_chg_clr", {7'd0, chg}, 8'h00);

        // Latency: din[0] 0->1 updates dout after edge 6
        din = 8'h01;
        step(5);
        check_eq("lat_pre_dout", dout, 8'h00);
        check_eq("lat_pre_rise", rise, 8'h00);
        step(1);
        check_eq("lat_dout", dout, 8'h01);
        check_eq("lat_rise", rise, ed(8'h01));
        check_eq("lat_chg", {7'd0, chg}, ed(8'h01));
        step(1);
        check_eq("lat_rise_clr", rise, 8'h00);
        check_eq("lat_chg_clr", {7'd0, chg}, 8'h00);

        // 3-cycle glitch on din[3] is rejected
        acc_dout = '0;
        acc_rise = '0;
        din = 8'h09;
        step_acc(3);
        din = 8'h01;
        step_acc(7);
        check_eq("glitch_dout", acc_dout, 8'h01);
        check_eq("glitch_rise", acc_rise, 8'h00);

        // 4-cycle pulse on din[3] is accepted, then falls
        din = 8'h09;
        step(4);
        din = 8'h01;
        step(1);
        check_eq("pulse_pre_dout", dout, 8'h01);
        step(1);
        check_eq("pulse_dout", dout, 8'h09);
        check_eq("pulse_rise", rise, ed(8'h08));
        step(3);
        check_eq("pulse_hold_dout", dout, 8'h09);
        check_eq("pulse_hold_fall", fall, 8'h00);
        step(1);
        check_eq("pulse_fall_dout", dout, 8'h01);
        check_eq("pulse_fall", fall, ed(8'h08));
        check_eq("pulse_fall_chg", {7'd0, chg}, ed(8'h01));

        // Interrupted run on din[4]: 3 disagree, 1 agree, 3 disagree
        acc_dout = '0;
        acc_rise = '0;
        din = 8'h11;
        step_acc(3);
        din = 8'h01;
        step_acc(1);
        din = 8'h11;
        step_acc(3);
        din = 8'h01;
        step_acc(8);
        check_eq("intr_dout", acc_dout, 8'h01);
        check_eq("intr_rise", acc_rise, 8'h00);

        // Simultaneous rise on four channels
        din = 8'h00;
        step(8);
        check_eq("sim_base_dout", dout, 8'h00);
        din = 8'h0F;
        step(5);
        check_eq("sim_pre_dout", dout, 8'h00);
        step(1);
        check_eq("sim_dout", dout, 8'h0F);
        check_eq("sim_rise", rise, ed(8'h0F));
        check_eq("sim_fall", fall, 8'h00);
        check_eq("sim_chg", {7'd0, chg}, ed(8'h01));
        step(1);
        check_eq("sim_rise_clr", rise, 8'h00);
        check_eq("sim_chg_clr", {7'd0, chg}, 8'h00);

        // Reset mid-filter discards pending counts
        din = 8'hFF;
        step(4);
        aresetn = 1'b0;
        step(1);
        check_eq("mid_rst_dout", dout, RV);
        check_eq("mid_rst_rise", rise, 8'h00);
        aresetn = 1'b1;
        acc_dout = '0;
        acc_rise = '0;
        step_acc(5);
        check_eq("mid_pre_dout", acc_dout, RV);
        check_eq("mid_pre_rise", acc_rise, 8'h00);
        step(1);
        check_eq("mid_dout", dout, 8'hFF);
        check_eq("mid_rise", rise, ed(8'h5A));
        check_eq("mid_fall", fall, 8'h00);
        step(1);
        check_eq("mid_rise_clr", rise, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
